// File: rtl/i2c_pkg.sv
// Shared I2C physical-layer definitions: default filter geometry, bus event codes
// and the bus ownership state used by the PHY and the controllers above it.
package i2c_pkg;

  localparam int I2C_SYNC_STAGES = 2;
  localparam int I2C_FILTER_LEN  = 4;

  typedef enum logic [1:0] {
    EV_NONE,
    EV_START,
    EV_STOP
  } i2c_event_e;

  typedef enum logic {
    BUS_IDLE,
    BUS_BUSY
  } i2c_bus_state_e;

  // An SDA edge only counts as START/STOP when SCL was high before and after it,
  // so simultaneous SCL/SDA transitions classify as EV_NONE.
  function automatic i2c_event_e classify_edge(
    input logic scl_q,
    input logic scl,
    input logic sda_q,
    input logic sda
  );
    i2c_event_e ev;
    ev = EV_NONE;
    if (scl_q && scl && sda_q && !sda) begin
      ev = EV_START;
    end else if (scl_q && scl && !sda_q && sda) begin
      ev = EV_STOP;
    end
    return ev;
  endfunction

endpackage

// File: rtl/i2c_line_filter.sv
// One pad input line: reset-to-1 synchroniser chain followed by a glitch filter that
// only follows the synchronised level after FILTER_LEN consecutive disagreeing cycles.
module i2c_line_filter
  import i2c_pkg::*;
#(
  parameter int SYNC_STAGES = I2C_SYNC_STAGES,
  parameter int FILTER_LEN  = I2C_FILTER_LEN
) (
  input  logic I_CLK,
  input  logic I_RESET,
  input  logic I_RAW,
  output logic O_LEVEL
);

  localparam int CNT_W = $clog2(FILTER_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic [CNT_W-1:0]       cnt;

  assign sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], I_RAW};
    end
  end

  // Any cycle of agreement restarts the count, so short pulses never reach CNT_LAST.
  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      cnt     <= '0;
      O_LEVEL <= 1'b1;
    end else if (sync == O_LEVEL) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt     <= '0;
      O_LEVEL <= sync;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/i2c_bus_phy.sv
// Multi-channel open-drain I2C PHY: pad drivers, filtered line levels, START/STOP
// detection, bus ownership tracking with idle timeout, and SDA arbitration-loss pulses.
module i2c_bus_phy
  import i2c_pkg::*;
#(
  parameter int CHANNELS     = 1,
  parameter int SYNC_STAGES  = I2C_SYNC_STAGES,
  parameter int FILTER_LEN   = I2C_FILTER_LEN,
  parameter int IDLE_TIMEOUT = 0
) (
  input  logic                I_CLK,
  input  logic                I_RESET,
  input  logic [CHANNELS-1:0] I_SCL_T,
  input  logic [CHANNELS-1:0] I_SDA_T,
  inout  wire  [CHANNELS-1:0] IO_SCL,
  inout  wire  [CHANNELS-1:0] IO_SDA,
  output logic [CHANNELS-1:0] O_SCL,
  output logic [CHANNELS-1:0] O_SDA,
  output logic [CHANNELS-1:0] O_START,
  output logic [CHANNELS-1:0] O_STOP,
  output logic [CHANNELS-1:0] O_BUSY,
  output logic [CHANNELS-1:0] O_ARB_LOST
);

  localparam int DELAY  = SYNC_STAGES + FILTER_LEN;
  localparam int IDLE_W = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_TIMEOUT);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic              scl;
    logic              sda;
    logic              scl_q;
    logic              sda_q;
    logic [DELAY-1:0]  sda_t_d;
    logic [IDLE_W-1:0] idle_cnt;
    logic [IDLE_W-1:0] idle_cnt_nxt;
    logic              timeout;
    logic              arb_c;
    logic              start_q;
    logic              stop_q;
    logic              arb_q;
    i2c_event_e        ev;
    i2c_bus_state_e    state;
    i2c_bus_state_e    state_nxt;

    // Open-drain pads are never driven high and do not depend on reset.
    assign IO_SCL[c] = I_SCL_T[c] ? 1'bz : 1'b0;
    assign IO_SDA[c] = I_SDA_T[c] ? 1'bz : 1'b0;

    i2c_line_filter #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILTER_LEN  (FILTER_LEN)
    ) u_scl_filter (
      .I_CLK   (I_CLK),
      .I_RESET (I_RESET),
      .I_RAW   (IO_SCL[c]),
      .O_LEVEL (scl)
    );

    i2c_line_filter #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILTER_LEN  (FILTER_LEN)
    ) u_sda_filter (
      .I_CLK   (I_CLK),
      .I_RESET (I_RESET),
      .I_RAW   (IO_SDA[c]),
      .O_LEVEL (sda)
    );

    always_comb begin
      ev           = classify_edge(scl_q, scl, sda_q, sda);
      timeout      = (IDLE_TIMEOUT > 0) && (idle_cnt == IDLE_MAX);
      idle_cnt_nxt = idle_cnt;
      state_nxt    = state;
      // sda_t_d lines our own SDA release up with the filtered SDA it is compared to.
      arb_c        = (state == BUS_BUSY) && !scl_q && scl && sda_t_d[DELAY-1] && !sda;

      if (!(scl && sda)) begin
        idle_cnt_nxt = '0;
      end else if (idle_cnt != IDLE_MAX) begin
        idle_cnt_nxt = idle_cnt + IDLE_W'(1);
      end

      // A START coinciding with the timeout keeps the bus owned.
      case (state)
        BUS_IDLE: if (ev == EV_START) state_nxt = BUS_BUSY;
        BUS_BUSY: if (ev != EV_START && (ev == EV_STOP || timeout)) state_nxt = BUS_IDLE;
        default:  state_nxt = BUS_IDLE;
      endcase
    end

    always_ff @(posedge I_CLK) begin
      if (I_RESET) begin
        scl_q    <= 1'b1;
        sda_q    <= 1'b1;
        sda_t_d  <= '1;
        idle_cnt <= '0;
        state    <= BUS_IDLE;
        start_q  <= 1'b0;
        stop_q   <= 1'b0;
        arb_q    <= 1'b0;
      end else begin
        scl_q    <= scl;
        sda_q    <= sda;
        sda_t_d  <= {sda_t_d[DELAY-2:0], I_SDA_T[c]};
        idle_cnt <= idle_cnt_nxt;
        state    <= state_nxt;
        start_q  <= (ev == EV_START);
        stop_q   <= (ev == EV_STOP);
        arb_q    <= arb_c;
      end
    end

    assign O_SCL[c]      = scl;
    assign O_SDA[c]      = sda;
    assign O_START[c]    = start_q;
    assign O_STOP[c]     = stop_q;
    assign O_BUSY[c]     = (state == BUS_BUSY);
    assign O_ARB_LOST[c] = arb_q;
  end

endmodule
